// File: rtl/lsu_mem_pkg.sv
// Shared types and helpers for the LSU memory responder.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  localparam int unsigned DEFAULT_NUM_WORDS = 32;
  localparam int unsigned DEFAULT_WORD_SIZE = 32;

  // Word index from a byte address; byte offset dropped, upper bits wrap.
  function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                           input int unsigned num_words);
    return (addr >> 2) & (num_words - 1);
  endfunction

endpackage

// File: rtl/lsu_resp_channel.sv
// One request channel: accepts a request, waits LATENCY cycles
// (stretched by stall_i), then pulses fire_o for one cycle.
module lsu_resp_channel
  import lsu_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  logic stall_i,
  output logic fire_o
);

  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_o = (state_q == IDLE);
    fire_o  = (state_q == RESP);
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          // The WAIT cycles plus the RESP cycle together span LATENCY cycles,
          // so a single-cycle latency goes straight to RESP.
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!stall_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU shim: one load and one store channel
// backed by a small word-addressed memory, with store-to-load forwarding.
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = DEFAULT_NUM_WORDS,
  parameter int unsigned WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int unsigned LOAD_LATENCY  = 2,
  parameter int unsigned STORE_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_req_valid_i,
  output logic                          load_req_ready_o,
  input  logic [31:0]                   load_req_addr_i,
  input  logic                          store_req_valid_i,
  output logic                          store_req_ready_o,
  input  logic [31:0]                   store_req_addr_i,
  input  logic [WORD_SIZE-1:0]          store_req_data_i,
  input  logic [WORD_SIZE/8-1:0]        store_req_be_i,
  input  logic                          stall_i,
  output logic                          load_mem_resp_o,
  output logic [WORD_SIZE-1:0]          load_rdata_o,
  output logic                          store_mem_resp_o,
  output logic [NUM_WORDS*WORD_SIZE-1:0] mem_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned BE_W  = WORD_SIZE / 8;

  logic load_accept, store_accept;
  logic load_fire,   store_fire;

  logic [IDX_W-1:0]     ld_idx_q,  ld_idx_d;
  logic [IDX_W-1:0]     st_idx_q,  st_idx_d;
  logic [WORD_SIZE-1:0] st_data_q, st_data_d;
  logic [BE_W-1:0]      st_be_q,   st_be_d;
  logic [WORD_SIZE-1:0] mem_q [NUM_WORDS];
  logic [WORD_SIZE-1:0] mem_d [NUM_WORDS];
  logic [WORD_SIZE-1:0] st_word;

  function automatic logic [WORD_SIZE-1:0] merge_bytes(
      input logic [WORD_SIZE-1:0] old_w,
      input logic [WORD_SIZE-1:0] new_w,
      input logic [BE_W-1:0]      be);
    logic [WORD_SIZE-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  lsu_resp_channel #(.LATENCY(LOAD_LATENCY)) u_load_chan (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (load_req_valid_i),
    .ready_o (load_req_ready_o),
    .stall_i (stall_i),
    .fire_o  (load_fire)
  );

  lsu_resp_channel #(.LATENCY(STORE_LATENCY)) u_store_chan (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (store_req_valid_i),
    .ready_o (store_req_ready_o),
    .stall_i (stall_i),
    .fire_o  (store_fire)
  );

  assign load_accept  = load_req_valid_i  && load_req_ready_o;
  assign store_accept = store_req_valid_i && store_req_ready_o;

  always_comb begin
    ld_idx_d  = ld_idx_q;
    st_idx_d  = st_idx_q;
    st_data_d = st_data_q;
    st_be_d   = st_be_q;
    if (load_accept) ld_idx_d = IDX_W'(word_idx(load_req_addr_i, NUM_WORDS));
    if (store_accept) begin
      st_idx_d  = IDX_W'(word_idx(store_req_addr_i, NUM_WORDS));
      st_data_d = store_req_data_i;
      st_be_d   = store_req_be_i;
    end
  end

  assign st_word = merge_bytes(mem_q[st_idx_q], st_data_q, st_be_q);

  always_comb begin
    mem_d = mem_q;
    if (store_fire) mem_d[st_idx_q] = st_word;
  end

  // A load completing alongside a store to the same word sees the merged data.
  always_comb begin
    load_rdata_o = '0;
    if (load_fire) begin
      load_rdata_o = (store_fire && (st_idx_q == ld_idx_q)) ? st_word
                                                            : mem_q[ld_idx_q];
    end
  end

  assign load_mem_resp_o  = load_fire;
  assign store_mem_resp_o = store_fire;

  always_comb begin
    mem_o = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      mem_o[i*WORD_SIZE +: WORD_SIZE] = mem_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_idx_q  <= '0;
      st_idx_q  <= '0;
      st_data_q <= '0;
      st_be_q   <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      ld_idx_q  <= ld_idx_d;
      st_idx_q  <= st_idx_d;
      st_data_q <= st_data_d;
      st_be_q   <= st_be_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed self-checking bench for lsu_mem_responder.
module tb_lsu_mem_responder;

  localparam int unsigned NW = 32;
  localparam int unsigned WS = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_req_valid;
  logic             load_req_ready;
  logic [31:0]      load_req_addr;
  logic             store_req_valid;
  logic             store_req_ready;
  logic [31:0]      store_req_addr;
  logic [WS-1:0]    store_req_data;
  logic [WS/8-1:0]  store_req_be;
  logic             stall;
  logic             load_mem_resp;
  logic [WS-1:0]    load_rdata;
  logic             store_mem_resp;
  logic [NW*WS-1:0] mem;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lsu_mem_responder #(
    .NUM_WORDS     (NW),
    .WORD_SIZE     (WS),
    .LOAD_LATENCY  (2),
    .STORE_LATENCY (1)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .load_req_valid_i  (load_req_valid),
    .load_req_ready_o  (load_req_ready),
    .load_req_addr_i   (load_req_addr),
    .store_req_valid_i (store_req_valid),
    .store_req_ready_o (store_req_ready),
    .store_req_addr_i  (store_req_addr),
    .store_req_data_i  (store_req_data),
    .store_req_be_i    (store_req_be),
    .stall_i           (stall),
    .load_mem_resp_o   (load_mem_resp),
    .load_rdata_o      (load_rdata),
    .store_mem_resp_o  (store_mem_resp),
    .mem_o             (mem)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_req_valid = 1'b0; load_req_addr = '0;
    store_req_valid = 1'b0; store_req_addr = '0;
    store_req_data = '0; store_req_be = '0; stall = 1'b0;
    step(); step();
    total_cnt++;
    if (load_req_ready !== 1'b1) $display("FAIL reset_load_ready: got %b want 1", load_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (store_req_ready !== 1'b1) $display("FAIL reset_store_ready: got %b want 1", store_req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({load_mem_resp, store_mem_resp} !== 2'b00)
      $display("FAIL reset_resp: got %b%b want 00", load_mem_resp, store_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (load_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", load_rdata);
    else pass_cnt++;
    total_cnt++;
    if (mem !== '0) $display("FAIL reset_mem: memory not all zero");
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic [WS-1:0] exp;
    store_req_valid = 1'b1; store_req_addr = 32'h8;
    store_req_data = 32'hDEADBEEF; store_req_be = 4'hF;
    step();  // T+1
    store_req_valid = 1'b0;
    total_cnt++;
    if (store_mem_resp !== 1'b1) $display("FAIL store_resp_t1: got %b want 1", store_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (store_req_ready !== 1'b0) $display("FAIL store_ready_t1: got %b want 0", store_req_ready);
    else pass_cnt++;
    step();  // T+2
    total_cnt++;
    if (store_mem_resp !== 1'b0) $display("FAIL store_resp_t2: got %b want 0", store_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (store_req_ready !== 1'b1) $display("FAIL store_ready_t2: got %b want 1", store_req_ready);
    else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      exp = (i == 2) ? 32'hDEADBEEF : 32'h0;
      total_cnt++;
      if (mem[i*WS +: WS] !== exp)
        $display("FAIL store_mem_word%0d: got %h want %h", i, mem[i*WS +: WS], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    load_req_valid = 1'b1; load_req_addr = 32'h8;
    step();  // T+1
    load_req_valid = 1'b0;
    total_cnt++;
    if (load_req_ready !== 1'b0) $display("FAIL load_ready_t1: got %b want 0", load_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (load_mem_resp !== 1'b0) $display("FAIL load_resp_t1: got %b want 0", load_mem_resp);
    else pass_cnt++;
    step();  // T+2
    total_cnt++;
    if (load_mem_resp !== 1'b1) $display("FAIL load_resp_t2: got %b want 1", load_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (load_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata_t2: got %h want deadbeef", load_rdata);
    else pass_cnt++;
    total_cnt++;
    if (load_req_ready !== 1'b0) $display("FAIL load_ready_t2: got %b want 0", load_req_ready);
    else pass_cnt++;
    step();  // T+3
    total_cnt++;
    if (load_req_ready !== 1'b1) $display("FAIL load_ready_t3: got %b want 1", load_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (load_mem_resp !== 1'b0) $display("FAIL load_resp_t3: got %b want 0", load_mem_resp);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int pulses;
    logic exp;
    pulses = 0;
    load_req_valid = 1'b1; load_req_addr = 32'h8;
    for (int k = 1; k <= 7; k++) begin
      step();
      load_req_valid = 1'b0;
      stall = (k <= 3);
      exp = (k == 5);
      if (load_mem_resp === 1'b1) pulses++;
      total_cnt++;
      if (load_mem_resp !== exp)
        $display("FAIL stall_resp_t%0d: got %b want %b", k, load_mem_resp, exp);
      else pass_cnt++;
    end
    stall = 1'b0;
    total_cnt++;
    if (pulses != 1) $display("FAIL stall_pulse_count: got %0d want 1", pulses);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    load_req_valid = 1'b1; load_req_addr = 32'h4;  // T-1
    step();  // T
    load_req_valid = 1'b0;
    store_req_valid = 1'b1; store_req_addr = 32'h4;
    store_req_data = 32'h11223344; store_req_be = 4'h3;
    step();  // T+1
    store_req_valid = 1'b0;
    total_cnt++;
    if ({load_mem_resp, store_mem_resp} !== 2'b11)
      $display("FAIL fwd_both_resp: got %b%b want 11", load_mem_resp, store_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (load_rdata !== 32'h00003344) $display("FAIL fwd_rdata: got %h want 00003344", load_rdata);
    else pass_cnt++;
    step();  // T+2
    total_cnt++;
    if (mem[1*WS +: WS] !== 32'h00003344)
      $display("FAIL fwd_mem_word1: got %h want 00003344", mem[1*WS +: WS]);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    load_req_valid = 1'b1; load_req_addr = 32'h88;
    step();  // T+1: ready low, this second request must be ignored
    load_req_addr = 32'h4;
    step();  // T+2
    load_req_valid = 1'b0;
    total_cnt++;
    if (load_mem_resp !== 1'b1) $display("FAIL alias_resp: got %b want 1", load_mem_resp);
    else pass_cnt++;
    total_cnt++;
    if (load_rdata !== 32'hDEADBEEF) $display("FAIL alias_rdata: got %h want deadbeef", load_rdata);
    else pass_cnt++;
    for (int k = 3; k <= 5; k++) begin
      step();
      total_cnt++;
      if (load_mem_resp !== 1'b0) $display("FAIL alias_no_second_t%0d: got %b want 0", k, load_mem_resp);
      else pass_cnt++;
    end
    total_cnt++;
    if (load_req_ready !== 1'b1) $display("FAIL alias_ready: got %b want 1", load_req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load_req_valid = 1'b1; load_req_addr = 32'h8;
    step();  // T+1, load in WAIT
    load_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (load_mem_resp !== 1'b0) $display("FAIL rstmid_resp_in_reset: got %b want 0", load_mem_resp);
    else pass_cnt++;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total_cnt++;
      if (load_mem_resp !== 1'b0) $display("FAIL rstmid_resp_after%0d: got %b want 0", k, load_mem_resp);
      else pass_cnt++;
    end
    total_cnt++;
    if (load_req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", load_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (mem !== '0) $display("FAIL rstmid_mem: word2=%h word1=%h want 0", mem[2*WS +: WS], mem[1*WS +: WS]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_stall();
    test_forward();
    test_alias();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
